// File: rtl/input_cmd_queue.sv
// input_cmd_queue: merges debounced key ticks into a pending set and queues them as 3-bit command codes in a FIFO.
// Define CMD_STATS_EN to add the saturating drop_cnt output that counts coalesced presses.
module input_cmd_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  pad_Sd,
    input  logic                  pad_Rd,
    input  logic                  pad_Ld,
    input  logic                  pad_Dd,
    input  logic                  bttn_Dd,
    input  logic                  bttn_Rd,
    input  logic                  bttn_Ld,
    input  logic                  bttn_Ud,
    input  logic                  flush,
    input  logic                  cmd_ready,
    output logic                  cmd_valid,
    output logic [2:0]            cmd_code,
    output logic [DEPTH_LOG2:0]   cmd_level,
    output logic                  coalesce
`ifdef CMD_STATS_EN
    ,output logic [15:0]          drop_cnt
`endif
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;
    localparam lvl_t FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0] ticks;
    logic [7:0] pending_q, pending_d, push_oh;
    logic [2:0] mem_q [DEPTH];
    logic [2:0] mem_d [DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    lvl_t       level_q, level_d;
    logic [2:0] cmd_code_q, cmd_code_d, push_idx;
    logic       coalesce_q, coalesce_d, push, pop, full;

    assign ticks = {bttn_Ud, bttn_Ld, bttn_Rd, bttn_Dd, pad_Dd, pad_Ld, pad_Rd, pad_Sd};

    always_comb begin
        push_idx = '0;
        for (int i = 7; i >= 0; i--) if (pending_q[i]) push_idx = 3'(i);
        full = level_q == FULL_LVL;
        push = |pending_q && !full && !flush;
        pop = level_q != '0 && cmd_ready && !flush;
        push_oh = push ? 8'(1) << push_idx : '0;
        // a fresh tick re-arms its bit even while that bit is being pushed
        pending_d = flush ? '0 : (pending_q & ~push_oh) | ticks;
        coalesce_d = !flush && |(ticks & pending_q & ~push_oh);
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = push_idx;
        wr_ptr_d = flush ? '0 : wr_ptr_q + ptr_t'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ptr_t'(pop);
        level_d = flush ? '0 : level_q + lvl_t'(push) - lvl_t'(pop);
        cmd_code_d = level_d == '0 ? '0 : mem_d[rd_ptr_d];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cmd_code_q <= '0;
            coalesce_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cmd_code_q <= cmd_code_d;
            coalesce_q <= coalesce_d;
        end
    end

    assign cmd_valid = level_q != '0;
    assign cmd_code  = cmd_code_q;
    assign cmd_level = level_q;
    assign coalesce  = coalesce_q;

`ifdef CMD_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = flush ? '0 : (coalesce_d && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule
